// File: rtl/melody_sequencer.sv
// Melody sequencer: steps through a writable (note, duration) table and drives
// the synth's play/note inputs, with tick-based timing and an optional silent gap.
module melody_sequencer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int SEQ_LEN   = 16,
  parameter int GAP_TICKS = 1,
  localparam int AW = $clog2(SEQ_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_note,
  input  logic [7:0]    wr_dur,
  output logic          play,
  output logic [7:0]    note,
  output logic          busy,
  output logic [AW-1:0] step,
  output logic          done
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int GW  = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(DIV - 1);
  localparam logic [AW-1:0] STEP_LAST = AW'(SEQ_LEN - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_TICKS);

  typedef enum logic [2:0] {IDLE, FETCH, NOTE, GAP, DONE} state_t;

  state_t        state, state_next;
  logic [7:0]    mem_note [SEQ_LEN];
  logic [7:0]    mem_dur  [SEQ_LEN];
  logic [7:0]    fetch_note, fetch_dur;
  logic [7:0]    dur_cnt, dur_next;
  logic [PW-1:0] presc, presc_next;
  logic [GW-1:0] gap_cnt, gap_next;
  logic [AW-1:0] step_next;
  logic [7:0]    note_next;
  logic          play_next, done_next;
  logic          tick, take_adv, take_end;

  // Table storage is deliberately not reset so a melody survives a reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_note[wr_addr] <= wr_note;
      mem_dur[wr_addr]  <= wr_dur;
    end
  end

  assign fetch_note = mem_note[step];
  assign fetch_dur  = mem_dur[step];
  assign tick       = (presc == TICK_LAST);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      step    <= '0;
      note    <= '0;
      play    <= 1'b0;
      done    <= 1'b0;
      dur_cnt <= '0;
      presc   <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= state_next;
      step    <= step_next;
      note    <= note_next;
      play    <= play_next;
      done    <= done_next;
      dur_cnt <= dur_next;
      presc   <= presc_next;
      gap_cnt <= gap_next;
    end
  end

  // End-of-sequence (terminator or table wrap) is shared by FETCH and advance;
  // a loop restart from step 0 would spin forever, so it finishes instead.
  always_comb begin
    state_next = state;
    step_next  = step;
    note_next  = note;
    play_next  = play;
    done_next  = 1'b0;
    dur_next   = dur_cnt;
    presc_next = presc;
    gap_next   = gap_cnt;
    take_adv   = 1'b0;
    take_end   = 1'b0;

    unique case (state)
      IDLE: begin
        if (!stop && start) begin
          step_next  = '0;
          state_next = FETCH;
        end
      end
      FETCH: begin
        presc_next = '0;
        if (fetch_dur == 8'd0) begin
          take_end = 1'b1;
        end else begin
          state_next = NOTE;
          note_next  = fetch_note;
          play_next  = (fetch_note != 8'd0);
          dur_next   = fetch_dur;
        end
      end
      NOTE: begin
        presc_next = tick ? '0 : presc + 1'b1;
        if (tick) begin
          dur_next = dur_cnt - 8'd1;
          if (dur_cnt == 8'd1) begin
            if (GAP_TICKS > 0) begin
              play_next  = 1'b0;
              gap_next   = GAP_LOAD;
              state_next = GAP;
            end else begin
              take_adv = 1'b1;
            end
          end
        end
      end
      GAP: begin
        presc_next = tick ? '0 : presc + 1'b1;
        if (tick) begin
          gap_next = gap_cnt - 1'b1;
          if (gap_cnt == GW'(1)) take_adv = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (take_adv) begin
      if (step == STEP_LAST) begin
        take_end = 1'b1;
      end else begin
        step_next  = step + 1'b1;
        state_next = FETCH;
      end
    end

    if (take_end) begin
      if (loop && (step != '0)) begin
        step_next  = '0;
        state_next = FETCH;
      end else begin
        state_next = DONE;
        play_next  = 1'b0;
        done_next  = 1'b1;
      end
    end

    if (stop && (state != IDLE)) begin
      state_next = IDLE;
      step_next  = step;
      play_next  = 1'b0;
      note_next  = '0;
      done_next  = 1'b0;
      presc_next = '0;
    end
  end

endmodule
